// File: rtl/key_scan_4.sv
// Debounced 4-key scanner: presents one one-hot code per press and holds it until ack.
// Optional auto-repeat of a held key is enabled by defining KEY_SCAN_AUTOREPEAT_EN.
module key_scan_4 #(
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned REPEAT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_raw,
  input  logic       ack,
  output logic [3:0] a,
  output logic       valid
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, VALID, RELEASE} state_t;

  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  state_t      state;
  logic [3:0]  sync1;
  logic [3:0]  ks;
  logic [3:0]  cand;
  logic [15:0] cnt;
  logic        cand_hit;

`ifdef KEY_SCAN_AUTOREPEAT_EN
  localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rpt;
`endif

  // Highest-index key wins when several are pressed together.
  function automatic logic [3:0] top_one_hot(input logic [3:0] v);
    if (v[3])      return 4'b1000;
    else if (v[2]) return 4'b0100;
    else if (v[1]) return 4'b0010;
    else if (v[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  assign cand_hit = |(ks & cand);

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below reads the pre-edge values of cnt, cand and ks regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sync1 <= 4'b0000;
      ks    <= 4'b0000;
      cand  <= 4'b0000;
      cnt   <= 16'd0;
      a     <= 4'b0000;
      valid <= 1'b0;
`ifdef KEY_SCAN_AUTOREPEAT_EN
      rpt   <= 16'd0;
`endif
    end else begin
      sync1 <= key_raw;
      ks    <= sync1;
      case (state)
        IDLE: begin
          a     <= 4'b0000;
          valid <= 1'b0;
          if (ks != 4'b0000) begin
            cand  <= top_one_hot(ks);
            cnt   <= 16'd0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          // Only the captured key matters; other keys neither restart nor retarget.
          if (!cand_hit)            state <= IDLE;
          else if (cnt == DEB_LAST) state <= VALID;
          else                      cnt   <= cnt + 16'd1;
        end
        VALID: begin
          a     <= cand;
          valid <= 1'b1;
          // ack is honoured only once valid is actually visible downstream.
          if (valid && ack) begin
            a     <= 4'b0000;
            valid <= 1'b0;
            cnt   <= 16'd0;
            state <= RELEASE;
`ifdef KEY_SCAN_AUTOREPEAT_EN
            rpt   <= 16'd0;
`endif
          end
        end
        RELEASE: begin
          if (ks != 4'b0000)        cnt   <= 16'd0;
          else if (cnt == DEB_LAST) state <= IDLE;
          else                      cnt   <= cnt + 16'd1;
`ifdef KEY_SCAN_AUTOREPEAT_EN
          if (!cand_hit) begin
            rpt <= 16'd0;
          end else if (rpt == RPT_LAST) begin
            rpt   <= 16'd0;
            state <= VALID;
          end else begin
            rpt <= rpt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_4.sv
// Directed self-checking bench for key_scan_4 (default parameters).
// Auto-repeat expectations follow KEY_SCAN_AUTOREPEAT_EN when it is defined.
module tb_key_scan_4;

  localparam int unsigned DEB = 16;
  localparam int unsigned RPT = 1000;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_raw;
  logic       ack;
  logic [3:0] a;
  logic       valid;

  int checks   = 0;
  int failures = 0;
  logic seen;

  key_scan_4 #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_raw),
    .ack     (ack),
    .a       (a),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n clocks, landing on a falling edge; a must never be multi-hot.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("a_onehot", {3'b000, ($countones(a) <= 1)}, 4'b0001);
    end
  endtask

  task automatic expect_code(input string tag, input logic [3:0] code);
    check({tag, "_valid"}, {3'b000, valid}, 4'b0001);
    check({tag, "_a"}, a, code);
  endtask

  task automatic expect_none(input string tag);
    check({tag, "_valid"}, {3'b000, valid}, 4'b0000);
    check({tag, "_a"}, a, 4'b0000);
  endtask

  initial begin
    rst_n   = 1'b0;
    key_raw = 4'b0000;
    ack     = 1'b0;
    cyc(2);
    expect_none("reset");
    rst_n = 1'b1;
    cyc(2);

    // Single press: latency boundary, hold through release, ack completes transfer.
    key_raw = 4'b0100;
    cyc(19);
    expect_none("press_edge18");
    cyc(1);
    expect_code("press_edge19", 4'b0100);
    key_raw = 4'b0000;
    cyc(30);
    expect_code("hold_until_ack", 4'b0100);
    ack = 1'b1;
    cyc(1);
    expect_none("after_ack");
    ack = 1'b0;
    cyc(20);

    // Short glitch with ack asserted: no code, back to idle.
    ack     = 1'b1;
    key_raw = 4'b0001;
    cyc(10);
    expect_none("glitch_10");
    key_raw = 4'b0000;
    cyc(30);
    expect_none("glitch_gone");
    ack = 1'b0;

    // Two keys together, other keys wiggle mid-debounce; highest index wins.
    key_raw = 4'b1010;
    cyc(8);
    key_raw = 4'b1110;
    cyc(4);
    key_raw = 4'b1010;
    cyc(7);
    expect_none("multi_edge18");
    cyc(1);
    expect_code("multi_edge19", 4'b1000);
    ack     = 1'b1;
    key_raw = 4'b0000;
    cyc(1);
    expect_none("multi_ack");
    ack = 1'b0;
    cyc(15);
    // Exactly 16 released samples since the ack edge: release debounce just completes.
    key_raw = 4'b0010;
    cyc(19);
    expect_none("second_edge18");
    cyc(1);
    expect_code("second_edge19", 4'b0010);

    // Held key after ack.
    ack = 1'b1;
    cyc(1);
    expect_none("held_ack");
    ack = 1'b0;
`ifndef KEY_SCAN_AUTOREPEAT_EN
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      cyc(1);
      seen |= valid;
    end
    check("held_no_repeat", {3'b000, seen}, 4'b0000);
`else
    cyc(RPT);
    expect_none("repeat_before");
    cyc(1);
    expect_code("repeat_fire", 4'b0010);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
`endif
    key_raw = 4'b0000;
    cyc(25);

    // Asynchronous reset mid-debounce and mid-valid.
    key_raw = 4'b0100;
    cyc(12);
    rst_n = 1'b0;
    #1;
    expect_none("rst_debounce");
    cyc(1);
    rst_n = 1'b1;
    cyc(19);
    expect_none("rst_redeb_edge18");
    cyc(1);
    expect_code("rst_redeb_edge19", 4'b0100);
    rst_n = 1'b0;
    #1;
    expect_none("rst_valid_async");
    cyc(1);
    rst_n = 1'b1;
    cyc(19);
    expect_none("rst2_edge18");
    cyc(1);
    expect_code("rst2_edge19", 4'b0100);
    ack     = 1'b1;
    key_raw = 4'b0000;
    cyc(1);
    ack = 1'b0;
    cyc(20);

    // Release bounce, then a press one sample too early stays in release.
    key_raw = 4'b0001;
    cyc(20);
    expect_code("bounce_press", 4'b0001);
    ack = 1'b1;
    cyc(1);
    ack  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      key_raw = ((i / 3) % 2 == 1) ? 4'b0001 : 4'b0000;
      cyc(1);
      seen |= valid;
    end
    key_raw = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      seen |= valid;
    end
    key_raw = 4'b0010;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      seen |= valid;
    end
    check("bounce_no_valid", {3'b000, seen}, 4'b0000);
    key_raw = 4'b0000;
    cyc(16);
    key_raw = 4'b1000;
    cyc(19);
    expect_none("recover_edge18");
    cyc(1);
    expect_code("recover_edge19", 4'b1000);
    ack = 1'b1;
    cyc(1);
    expect_none("recover_ack");
    ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_scan_4.md
KEY_SCAN_4 -- requirements
Module: key_scan_4

Interface
REQ-001 Parameter DEB_CYCLES, default 16, stable-sample count for press and release debounce; legal range 2..65535.
REQ-002 Parameter REPEAT_CYCLES, default 1000, auto-repeat interval in clocks; used only under KEY_SCAN_AUTOREPEAT_EN; legal range 2..65535.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 key_raw  input  4  asynchronous raw pushbuttons, active-high, bounce-prone.
REQ-006 ack  input  1  consumer accepts the current code; sampled only while valid=1.
REQ-007 a  output  4  one-hot key code driving the downstream 4x2 encoder; 4'b0000 when no code is presented.
REQ-008 valid  output  1  a holds a debounced, accepted-pending key.

Function
REQ-009 Each key_raw bit shall pass through a 2-flop synchronizer; the synchronized vector is ks.
REQ-010 States shall be IDLE, DEBOUNCE, VALID and RELEASE; a and valid shall be registered outputs.
REQ-011 IDLE: a=0, valid=0; if ks!=0, capture cand = one-hot of the highest-index set bit of ks, clear cnt, and go to DEBOUNCE.
REQ-012 DEBOUNCE: if ks bit selected by cand is 0, go to IDLE; else if cnt==DEB_CYCLES-1, go to VALID; else increment cnt.
REQ-013 A raw press held stable from edge 0 shall make valid=1 and a=cand after edge DEB_CYCLES+3 (edge 19 at default).
REQ-014 Other keys changing during DEBOUNCE shall neither restart the count nor change cand.
REQ-015 VALID: a=cand and valid=1 shall hold unchanged until ack=1 is sampled; key release while in VALID shall not drop valid.
REQ-016 ack=1 while valid=1 shall complete a transfer: on the next edge, valid=0, a=0, cnt=0, state RELEASE.
REQ-017 ack while valid=0 shall be ignored in every state.
REQ-018 RELEASE: any ks bit set shall clear cnt; ks==0 shall increment cnt; cnt==DEB_CYCLES-1 with ks==0 shall go to IDLE.
REQ-019 Exactly one code shall be emitted per press; a held key shall produce no further valid in RELEASE (unless REQ-024 applies).
REQ-020 a shall always be 4'b0000 or one-hot; it shall never hold more than one set bit.
REQ-021 cnt shall be 16 bits wide and saturate rather than wrap at DEB_CYCLES-1 or REPEAT_CYCLES-1.

Reset
REQ-022 rst_n=0 shall immediately, without a clock, force state IDLE, a=0, valid=0, cnt=0, cand=0 and clear both synchronizer stages.
REQ-023 Reset asserted mid-debounce or mid-VALID shall discard the pending key; after release, a still-held key shall be re-debounced from IDLE.

Configuration
REQ-024 With KEY_SCAN_AUTOREPEAT_EN defined, in RELEASE with the cand key still set in ks, a separate repeat counter shall count to REPEAT_CYCLES-1 and then re-enter VALID with the same a=cand, valid=1.
REQ-025 The repeat counter shall clear on entry to RELEASE and whenever the cand key is 0 in ks.
REQ-026 Without KEY_SCAN_AUTOREPEAT_EN, the repeat counter shall not exist and REQ-018/REQ-019 shall govern RELEASE exclusively.

Verification
REQ-027 key_raw=4'b0100 held, ack=0 -> valid=1, a=4'b0100 after edge 19 (DEB_CYCLES=16); both held until ack.
REQ-028 key_raw=4'b0001 for 10 cycles, then 0 -> valid never asserts; state returns to IDLE.
REQ-029 key_raw=4'b1010 simultaneously -> a=4'b1000 only; after ack and 16 cycles of all-released, a second press of 4'b0010 yields a=4'b0010.
REQ-030 Valid pending; ack pulsed 1 cycle -> next edge valid=0, a=0; key kept held 5000 cycles -> no new valid (macro off), or valid re-asserted after REPEAT_CYCLES cycles per ack (macro on).
REQ-031 rst_n driven low asynchronously at cycle 10 of DEBOUNCE and while valid=1 -> a=0 and valid=0 immediately; after rst_n=1 with key held, valid reasserts after DEB_CYCLES+3 edges.
REQ-032 Release bounce: after ack, key_raw toggles every 3 cycles for 40 cycles, then 0 -> IDLE reached exactly 16 cycles after the last synchronized 1; no spurious valid.
